// File: rtl/cipher_sequencer.sv
// Sequencing controller for the stream-cipher datapath: turns user strobes
// into key writes and encryption start pulses, and tracks the result handshake.
module cipher_sequencer #(
    parameter int KEY_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         in_valid,
    input  logic                         in_is_key,
    input  logic [7:0]                   in_byte,
    input  logic                         out_ack,
    input  logic                         enc_done,
    output logic                         key_wr_en,
    output logic [$clog2(KEY_BYTES)-1:0] key_wr_addr,
    output logic [7:0]                   key_wr_data,
    output logic                         enc_start,
    output logic [7:0]                   enc_data,
    output logic [2:0]                   state_out,
    output logic                         key_loaded,
    output logic                         overrun
);

    localparam int AW = $clog2(KEY_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENC_WAIT = 3'd1,
        OUT_HOLD = 3'd2,
        ERROR    = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            in_valid_q, out_ack_q;
    logic [AW-1:0]   key_ptr_q, key_ptr_d;
    logic            key_loaded_q, key_loaded_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            key_wr_en_q, key_wr_en_d;
    logic [AW-1:0]   key_wr_addr_q, key_wr_addr_d;
    logic [7:0]      key_wr_data_q, key_wr_data_d;
    logic            enc_start_q, enc_start_d;
    logic [7:0]      enc_data_q, enc_data_d;
    logic            rise_v, rise_a;

    assign rise_v = in_valid & ~in_valid_q;
    assign rise_a = out_ack & ~out_ack_q;

    always_comb begin
        state_d       = state_q;
        key_ptr_d     = key_ptr_q;
        key_loaded_d  = key_loaded_q;
        overrun_d     = overrun_q;
        cnt_d         = cnt_q;
        key_wr_en_d   = 1'b0;
        key_wr_addr_d = key_wr_addr_q;
        key_wr_data_d = key_wr_data_q;
        enc_start_d   = 1'b0;
        enc_data_d    = enc_data_q;
        unique case (state_q)
            IDLE: begin
                if (rise_v && in_is_key) begin
                    key_wr_en_d   = 1'b1;
                    key_wr_data_d = in_byte;
                    // A fresh key after a complete one restarts at byte 0
                    if (key_loaded_q) begin
                        key_loaded_d  = 1'b0;
                        key_wr_addr_d = '0;
                        key_ptr_d     = AW'(1);
                    end else begin
                        key_wr_addr_d = key_ptr_q;
                        key_ptr_d     = key_ptr_q + AW'(1);
                        if (key_ptr_q == AW'(KEY_BYTES - 1))
                            key_loaded_d = 1'b1;
                    end
                end else if (rise_v && key_loaded_q) begin
                    enc_data_d  = in_byte;
                    enc_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ENC_WAIT;
                end else if (rise_v) begin
                    state_d = ERROR;
                end
            end
            ENC_WAIT: begin
                if (rise_v)
                    overrun_d = 1'b1;
                if (enc_done)
                    state_d = OUT_HOLD;
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1))
                    state_d = ERROR;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            OUT_HOLD: begin
                if (rise_v)
                    overrun_d = 1'b1;
                if (rise_a)
                    state_d = IDLE;
            end
            ERROR: begin
                if (rise_a)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge registers reset high so a level present at reset release is no edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            in_valid_q    <= 1'b1;
            out_ack_q     <= 1'b1;
            key_ptr_q     <= '0;
            key_loaded_q  <= 1'b0;
            overrun_q     <= 1'b0;
            cnt_q         <= '0;
            key_wr_en_q   <= 1'b0;
            key_wr_addr_q <= '0;
            key_wr_data_q <= '0;
            enc_start_q   <= 1'b0;
            enc_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            in_valid_q    <= in_valid;
            out_ack_q     <= out_ack;
            key_ptr_q     <= key_ptr_d;
            key_loaded_q  <= key_loaded_d;
            overrun_q     <= overrun_d;
            cnt_q         <= cnt_d;
            key_wr_en_q   <= key_wr_en_d;
            key_wr_addr_q <= key_wr_addr_d;
            key_wr_data_q <= key_wr_data_d;
            enc_start_q   <= enc_start_d;
            enc_data_q    <= enc_data_d;
        end
    end

    assign key_wr_en   = key_wr_en_q;
    assign key_wr_addr = key_wr_addr_q;
    assign key_wr_data = key_wr_data_q;
    assign enc_start   = enc_start_q;
    assign enc_data    = enc_data_q;
    assign state_out   = state_q;
    assign key_loaded  = key_loaded_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Bench for cipher_sequencer: one instance with the default timeout and one
// with TIMEOUT_CYCLES=4, both driven by the same vector table.
module tb_cipher_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       in_valid, in_is_key, out_ack, enc_done;
    logic [7:0] in_byte;

    logic       m_we, m_st, m_kl, m_ov;
    logic [2:0] m_ad, m_s;
    logic [7:0] m_wd, m_ed;
    logic       t_we, t_st, t_kl, t_ov;
    logic [2:0] t_ad, t_s;
    logic [7:0] t_wd, t_ed;

    always #5 clk = ~clk;

    cipher_sequencer #(.KEY_BYTES(8), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_is_key(in_is_key),
        .in_byte(in_byte), .out_ack(out_ack), .enc_done(enc_done),
        .key_wr_en(m_we), .key_wr_addr(m_ad), .key_wr_data(m_wd),
        .enc_start(m_st), .enc_data(m_ed), .state_out(m_s),
        .key_loaded(m_kl), .overrun(m_ov)
    );

    cipher_sequencer #(.KEY_BYTES(8), .TIMEOUT_CYCLES(4)) dut_t4 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_is_key(in_is_key),
        .in_byte(in_byte), .out_ack(out_ack), .enc_done(enc_done),
        .key_wr_en(t_we), .key_wr_addr(t_ad), .key_wr_data(t_wd),
        .enc_start(t_st), .enc_data(t_ed), .state_out(t_s),
        .key_loaded(t_kl), .overrun(t_ov)
    );

    typedef struct {
        logic        v, k, a, d;
        logic [7:0]  b;
        logic [25:0] em, e4;
        string       name;
    } vec_t;

    typedef struct {
        logic [25:0] em, e4;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [25:0] E(input logic we, input logic [2:0] ad,
                                      input logic [7:0] wd, input logic st,
                                      input logic [7:0] ed, input logic [2:0] s,
                                      input logic kl, input logic ov);
        return {we, ad, wd, st, ed, s, kl, ov};
    endfunction

    function automatic logic [25:0] act_m();
        return {m_we, m_ad, m_wd, m_st, m_ed, m_s, m_kl, m_ov};
    endfunction

    function automatic logic [25:0] act_t();
        return {t_we, t_ad, t_wd, t_st, t_ed, t_s, t_kl, t_ov};
    endfunction

    task automatic check(input string name, input logic [25:0] act,
                         input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (we,addr,wdata,start,edata,state,kl,ov)",
                     name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic k, input logic [7:0] b,
                                input logic a, input logic d,
                                input logic [25:0] em, input logic [25:0] e4,
                                input string name);
        vec_t r;
        r.v = v; r.k = k; r.b = b; r.a = a; r.d = d;
        r.em = em; r.e4 = e4; r.name = name;
        tbl.push_back(r);
    endfunction

    task automatic step(input logic v, input logic k, input logic [7:0] b,
                        input logic a, input logic d,
                        input logic [25:0] em, input logic [25:0] e4,
                        input string name);
        sb_t e;
        @(negedge clk);
        in_valid  = v;
        in_is_key = k;
        in_byte   = b;
        out_ack   = a;
        enc_done  = d;
        e.em = em; e.e4 = e4; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({e.name, "/main"}, act_m(), e.em);
            check({e.name, "/t4"}, act_t(), e.e4);
        end
    endtask

    task automatic async_reset(input string name);
        #1;
        nrst     = 1'b0;
        in_valid = 1'b0;
        #1;
        check({name, "/main"}, act_m(), 26'd0);
        check({name, "/t4"}, act_t(), 26'd0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    logic [25:0] z, er, w, t3, h, id;

    initial begin
        nrst = 1'b0;
        in_valid = 1'b1;
        in_is_key = 1'b0;
        in_byte = 8'h00;
        out_ack = 1'b0;
        enc_done = 1'b0;

        z  = E(0, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        er = E(0, 0, 8'h00, 0, 8'h00, 3'd3, 0, 0);
        add(1, 0, 8'h55, 0, 0, z, z, "hold_hi");
        add(0, 0, 8'h00, 0, 0, z, z, "idle0");
        add(1, 0, 8'h55, 0, 0, er, er, "pt_nokey");
        add(0, 0, 8'h00, 0, 0, er, er, "err_hold");
        add(1, 0, 8'h56, 0, 0, er, er, "err_ign_v");
        add(0, 0, 8'h00, 1, 0, z, z, "err_ack");
        add(0, 0, 8'h00, 0, 0, z, z, "idle1");
        for (int i = 0; i < 8; i++) begin
            add(1, 1, 8'h10 + 8'(i), 0, 0,
                E(1, 3'(i), 8'h10 + 8'(i), 0, 8'h00, 3'd0, i == 7, 0),
                E(1, 3'(i), 8'h10 + 8'(i), 0, 8'h00, 3'd0, i == 7, 0), "key_wr");
            add(0, 0, 8'h00, 0, 0,
                E(0, 3'(i), 8'h10 + 8'(i), 0, 8'h00, 3'd0, i == 7, 0),
                E(0, 3'(i), 8'h10 + 8'(i), 0, 8'h00, 3'd0, i == 7, 0), "key_gap");
        end

        w  = E(0, 7, 8'h17, 0, 8'hA5, 3'd1, 1, 0);
        t3 = E(0, 7, 8'h17, 0, 8'hA5, 3'd3, 1, 0);
        h  = E(0, 7, 8'h17, 0, 8'hA5, 3'd2, 1, 0);
        id = E(0, 7, 8'h17, 0, 8'hA5, 3'd0, 1, 0);
        add(1, 0, 8'hA5, 0, 0, E(0, 7, 8'h17, 1, 8'hA5, 3'd1, 1, 0),
            E(0, 7, 8'h17, 1, 8'hA5, 3'd1, 1, 0), "start_a5");
        add(0, 0, 8'h00, 0, 0, w, w, "wait1");
        add(0, 0, 8'h00, 0, 0, w, w, "wait2");
        add(0, 0, 8'h00, 0, 0, w, w, "wait3");
        add(0, 0, 8'h00, 0, 0, w, t3, "timeout4");
        add(0, 0, 8'h00, 0, 0, w, t3, "wait5");
        add(0, 0, 8'h00, 0, 1, h, t3, "done5");
        add(0, 0, 8'h00, 0, 0, h, t3, "hold");
        add(0, 0, 8'h00, 1, 0, id, id, "ack");
        add(0, 0, 8'h00, 0, 0, id, id, "idle2");

        w = E(0, 7, 8'h17, 0, 8'h66, 3'd1, 1, 0);
        add(1, 0, 8'h66, 0, 0, E(0, 7, 8'h17, 1, 8'h66, 3'd1, 1, 0),
            E(0, 7, 8'h17, 1, 8'h66, 3'd1, 1, 0), "start_66");
        add(0, 0, 8'h00, 0, 0, w, w, "w66_1");
        add(0, 0, 8'h00, 0, 0, w, w, "w66_2");
        add(0, 0, 8'h00, 0, 0, w, w, "w66_3");
        add(0, 0, 8'h00, 0, 1, E(0, 7, 8'h17, 0, 8'h66, 3'd2, 1, 0),
            E(0, 7, 8'h17, 0, 8'h66, 3'd2, 1, 0), "done_at_to");
        add(0, 0, 8'h00, 1, 0, E(0, 7, 8'h17, 0, 8'h66, 3'd0, 1, 0),
            E(0, 7, 8'h17, 0, 8'h66, 3'd0, 1, 0), "ack66");
        add(0, 0, 8'h00, 0, 0, E(0, 7, 8'h17, 0, 8'h66, 3'd0, 1, 0),
            E(0, 7, 8'h17, 0, 8'h66, 3'd0, 1, 0), "idle3");

        w  = E(0, 7, 8'h17, 0, 8'h77, 3'd1, 1, 1);
        h  = E(0, 7, 8'h17, 0, 8'h77, 3'd2, 1, 1);
        id = E(0, 7, 8'h17, 0, 8'h77, 3'd0, 1, 1);
        add(1, 0, 8'h77, 0, 0, E(0, 7, 8'h17, 1, 8'h77, 3'd1, 1, 0),
            E(0, 7, 8'h17, 1, 8'h77, 3'd1, 1, 0), "start_77");
        add(0, 0, 8'h00, 0, 0, E(0, 7, 8'h17, 0, 8'h77, 3'd1, 1, 0),
            E(0, 7, 8'h17, 0, 8'h77, 3'd1, 1, 0), "w77");
        add(1, 0, 8'h3C, 0, 0, w, w, "ovr_wait");
        add(0, 0, 8'h00, 0, 1, h, h, "done77");
        add(1, 0, 8'h3C, 0, 0, h, h, "ovr_hold");
        add(0, 0, 8'h00, 0, 0, h, h, "hold77");
        add(1, 0, 8'h3C, 1, 0, id, id, "v_and_a");
        add(0, 0, 8'h00, 0, 0, id, id, "idle4");
        add(1, 1, 8'h21, 0, 0, E(1, 0, 8'h21, 0, 8'h77, 3'd0, 0, 1),
            E(1, 0, 8'h21, 0, 8'h77, 3'd0, 0, 1), "reload");
        add(0, 0, 8'h00, 0, 0, E(0, 0, 8'h21, 0, 8'h77, 3'd0, 0, 1),
            E(0, 0, 8'h21, 0, 8'h77, 3'd0, 0, 1), "reload_gap");

        repeat (3) @(posedge clk);
        #1;
        check("rst_state/main", act_m(), 26'd0);
        check("rst_state/t4", act_t(), 26'd0);
        @(negedge clk);
        nrst = 1'b1;

        foreach (tbl[i])
            step(tbl[i].v, tbl[i].k, tbl[i].b, tbl[i].a, tbl[i].d,
                 tbl[i].em, tbl[i].e4, tbl[i].name);

        for (int i = 1; i < 8; i++) begin
            step(1, 1, 8'h30 + 8'(i), 0, 0,
                 E(1, 3'(i), 8'h30 + 8'(i), 0, 8'h77, 3'd0, i == 7, 1),
                 E(1, 3'(i), 8'h30 + 8'(i), 0, 8'h77, 3'd0, i == 7, 1), "key2_wr");
            step(0, 0, 8'h00, 0, 0,
                 E(0, 3'(i), 8'h30 + 8'(i), 0, 8'h77, 3'd0, i == 7, 1),
                 E(0, 3'(i), 8'h30 + 8'(i), 0, 8'h77, 3'd0, i == 7, 1), "key2_gap");
        end
        step(1, 0, 8'h88, 0, 0, E(0, 7, 8'h37, 1, 8'h88, 3'd1, 1, 1),
             E(0, 7, 8'h37, 1, 8'h88, 3'd1, 1, 1), "start_88");
        async_reset("rst_enc");

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 8'h40 + 8'(i), 0, 0,
                 E(1, 3'(i), 8'h40 + 8'(i), 0, 8'h00, 3'd0, 0, 0),
                 E(1, 3'(i), 8'h40 + 8'(i), 0, 8'h00, 3'd0, 0, 0), "key3_wr");
            if (i < 2)
                step(0, 0, 8'h00, 0, 0,
                     E(0, 3'(i), 8'h40 + 8'(i), 0, 8'h00, 3'd0, 0, 0),
                     E(0, 3'(i), 8'h40 + 8'(i), 0, 8'h00, 3'd0, 0, 0), "key3_gap");
        end
        async_reset("rst_key");
        step(1, 1, 8'h50, 0, 0, E(1, 0, 8'h50, 0, 8'h00, 3'd0, 0, 0),
             E(1, 0, 8'h50, 0, 8'h00, 3'd0, 0, 0), "reload_addr0");
        step(0, 0, 8'h00, 0, 0, E(0, 0, 8'h50, 0, 8'h00, 3'd0, 0, 0),
             E(0, 0, 8'h50, 0, 8'h00, 3'd0, 0, 0), "reload0_gap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cipher_sequencer.md
# cipher_sequencer

Top-level sequencing controller for the stream-cipher datapath. It takes user-pin strobes (key bytes, plaintext bytes, output acknowledge) and turns them into key-register writes and single-cycle encryption start pulses. It watches the encryption block for completion and holds the design in an output-hold state until the user acknowledges the result. Its state output is the interface state consumed by the output holder, which clears to EMPTY whenever this block is in IDLE.

## Interface
- KEY_BYTES, 8, number of key bytes. Power of two, 2..16.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for enc_done before faulting. Range 2..255.
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  user strobe, already synchronized; acted on at its rising edge only
- in_is_key  in  1  qualifies in_valid: 1 = key byte, 0 = plaintext byte
- in_byte  in  8  user data byte, sampled on the in_valid rising-edge cycle
- out_ack  in  1  user acknowledge, already synchronized; acted on at its rising edge only
- enc_done  in  1  one-cycle completion pulse from the encryption block
- key_wr_en  out  1  one-cycle key-register write strobe
- key_wr_addr  out  $clog2(KEY_BYTES)  key byte index
- key_wr_data  out  8  key byte
- enc_start  out  1  one-cycle encryption start pulse
- enc_data  out  8  plaintext byte to the encryption block; held stable until the next start
- state_out  out  3  current state: IDLE=0, ENC_WAIT=1, OUT_HOLD=2, ERROR=3
- key_loaded  out  1  all KEY_BYTES key bytes have been written
- overrun  out  1  sticky: a strobe was dropped while busy; cleared only by reset

## Operation
- Edge detect:
  - rise_v = in_valid & !in_valid_q, and the same form for out_ack.
  - Both _q registers reset to 1, so a level already high at reset release is not treated as an edge.
- Registered outputs. All outputs are 0 after reset; state_out = IDLE and key_ptr = 0.
- IDLE:
  - rise_v & in_is_key:
    - key_wr_en=1, key_wr_addr=key_ptr, key_wr_data=in_byte.
    - If key_loaded=1, first clear key_loaded and write to address 0, with key_ptr then set to 1 (key reload).
    - Otherwise key_ptr increments. When key_ptr wraps from KEY_BYTES-1 to 0, key_loaded is set to 1.
  - rise_v & !in_is_key & key_loaded: enc_data=in_byte, enc_start=1, timeout counter cleared, go to ENC_WAIT.
  - rise_v & !in_is_key & !key_loaded: go to ERROR. No start pulse.
  - rise_a is ignored.
- ENC_WAIT:
  - Counter increments each cycle.
  - enc_done: go to OUT_HOLD.
  - Counter == TIMEOUT_CYCLES-1 without enc_done: go to ERROR.
  - enc_done in the same cycle as the timeout: enc_done wins.
  - Any rise_v sets overrun; the byte is dropped.
- OUT_HOLD:
  - rise_a: go to IDLE.
  - rise_v sets overrun and is dropped.
  - rise_v and rise_a in the same cycle: go to IDLE, overrun is set, and the byte is still dropped.
- ERROR:
  - rise_a: go to IDLE. key_loaded and key_ptr are unchanged.
  - rise_v is ignored; overrun is not set.
- enc_done outside ENC_WAIT is ignored.
- Asynchronous reset in any state returns every register to its reset value immediately, including mid-key-load and mid-encryption. enc_start and key_wr_en drop in the same instant.

## Timing
- A strobe edge sampled at clock edge N produces its response (key_wr_en, or enc_start plus the state change) in the cycle after edge N. Latency is 1 cycle. Each pulse is exactly 1 cycle wide.
- Consecutive accepted strobes need in_valid low for at least 1 sampled cycle between them.
- enc_done sampled at edge M: state_out = OUT_HOLD in the cycle after edge M. The output holder captures data on that same enc_done, so holder READY and OUT_HOLD coincide.
- Timeout: with enc_start in cycle S, the last legal enc_done cycle is S+TIMEOUT_CYCLES-1. ERROR is visible one cycle after that.
- rise_a at edge A: state_out = IDLE in the cycle after edge A. The holder goes EMPTY on the following edge.

## Test plan
- Key load:
  - Stimulus: 8 key strobes with bytes 0x10..0x17.
  - Required: key_wr_addr 0..7 with matching data, each key_wr_en 1 cycle; key_loaded rises one cycle after the 8th strobe.
- Encrypt then acknowledge:
  - Stimulus: after key load, plaintext 0xA5; enc_done 5 cycles after start; then out_ack.
  - Required: enc_start pulses once with enc_data=0xA5; state sequence 0→1→2; state returns to 0 one cycle after the ack edge.
- Timeout with TIMEOUT_CYCLES=4:
  - Stimulus: no enc_done.
  - Required: ERROR entered 4 cycles after enc_start; out_ack returns to IDLE with key_loaded still 1.
  - Repeat with enc_done on the timeout cycle: required to reach OUT_HOLD.
- Plaintext without key:
  - Stimulus: plaintext strobe right after reset.
  - Required: state goes to ERROR with no enc_start.
  - Stimulus: in_valid held high through reset release.
  - Required: no action.
- Overrun:
  - Stimulus: strobe 0x3C during ENC_WAIT and during OUT_HOLD.
  - Required: overrun=1, no enc_start, enc_data unchanged.
  - Stimulus: rise_v and rise_a in the same cycle in OUT_HOLD.
  - Required: IDLE with no start.
- Reset mid-operation:
  - Stimulus: assert nrst low during ENC_WAIT, then after 3 of 8 key writes.
  - Required: all outputs 0 and state IDLE immediately; a key reload starts at address 0.
